// File: rtl/shift_sched_if.sv
// Handshake bundle between two shift requesters, the scheduler and the result consumer.
// Latency: none, wires only.
// Backpressure: the bundle only carries gnt and out_ready; it adds no buffering.
//
// Ports (slave = scheduler view):
//   a_req/a_in/a_cnt -> a_gnt   requester A operation (operand, shift amount) and grant
//   b_req/b_in/b_cnt -> b_gnt   requester B, same meaning
//   out_valid/out_data/out_id   result, owner id (0 = A, 1 = B)
//   out_ready                   consumer accepts the result
//   busy                        scheduler not idle
interface shift_sched_if;
   logic        a_req;
   logic [15:0] a_in;
   logic [3:0]  a_cnt;
   logic        a_gnt;
   logic        b_req;
   logic [15:0] b_in;
   logic [3:0]  b_cnt;
   logic        b_gnt;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_id;
   logic        out_ready;
   logic        busy;

   modport slave (
      input  a_req, a_in, a_cnt,
      input  b_req, b_in, b_cnt,
      input  out_ready,
      output a_gnt, b_gnt,
      output out_valid, out_data, out_id,
      output busy
   );

   modport master (
      output a_req, a_in, a_cnt,
      output b_req, b_in, b_cnt,
      output out_ready,
      input  a_gnt, b_gnt,
      input  out_valid, out_data, out_id,
      input  busy
   );
endinterface

// File: rtl/shift_sched.sv
// Two-requester arbiter feeding one multi-cycle left shifter (up to STEP bits per cycle).
// Latency: out_valid rises ceil(cnt/STEP)+1 cycles after the grant cycle.
// Backpressure: result held in DONE until out_ready; no grant is issued until back in IDLE.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_sched_if.slave: requester A/B (req, in, cnt, gnt), result
//          (out_valid, out_data, out_id, out_ready) and busy
// Parameter STEP (1..15): maximum shift applied per SHIFT cycle.
// Macro SHFT_SCHED_RR_EN: defined -> round-robin between A and B on contention;
//                          undefined -> fixed priority, A always wins.
module shift_sched #(
   parameter int STEP = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   shift_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] STEP_W = 4'(STEP);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_acc;
   logic [15:0] w_acc_nxt;
   logic [3:0]  r_rem;
   logic [3:0]  w_rem_nxt;
   logic        r_id;
   logic        w_id_nxt;
   logic [15:0] r_out_data;
   logic        r_out_id;

   logic        w_gnt_ok;
   logic        w_a_prio;
   logic        w_a_gnt;
   logic        w_b_gnt;
   logic [3:0]  w_k;
   logic [3:0]  w_rem_left;
   logic        w_load_out;

   //------------------------------------------------------------------
   // Arbitration
   //------------------------------------------------------------------
`ifdef SHFT_SCHED_RR_EN
   // 1: A wins the next contention; flips to the loser on every grant.
   logic r_ptr;

   assign w_a_prio = r_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b1;
      end else if (w_a_gnt) begin
         r_ptr <= 1'b0;
      end else if (w_b_gnt) begin
         r_ptr <= 1'b1;
      end
   end
`else
   assign w_a_prio = 1'b1;
`endif

   // Grants are only combinational in IDLE; gating with rst_n keeps them low
   // while reset is asserted even if a requester is already presenting.
   assign w_gnt_ok = rst_n && (r_state == IDLE);
   assign w_a_gnt  = w_gnt_ok && bus.a_req && (!bus.b_req || w_a_prio);
   assign w_b_gnt  = w_gnt_ok && bus.b_req && !w_a_gnt;

   //------------------------------------------------------------------
   // Shift step: k = min(rem, STEP)
   //------------------------------------------------------------------
   assign w_k        = (r_rem < STEP_W) ? r_rem : STEP_W;
   assign w_rem_left = r_rem - w_k;

   //------------------------------------------------------------------
   // Next state / datapath
   //------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_rem_nxt   = r_rem;
      w_id_nxt    = r_id;

      unique case (r_state)
         IDLE: begin
            if (w_a_gnt) begin
               w_acc_nxt   = bus.a_in;
               w_rem_nxt   = bus.a_cnt;
               w_id_nxt    = 1'b0;
               w_state_nxt = (bus.a_cnt == 4'd0) ? DONE : SHIFT;
            end else if (w_b_gnt) begin
               w_acc_nxt   = bus.b_in;
               w_rem_nxt   = bus.b_cnt;
               w_id_nxt    = 1'b1;
               w_state_nxt = (bus.b_cnt == 4'd0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // Bits shifted past bit 15 are dropped, zeros enter at bit 0.
            w_acc_nxt = r_acc << w_k;
            w_rem_nxt = w_rem_left;
            if (w_rem_left == 4'd0) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // The visible result registers load only on entry to DONE so out_data and
   // out_id hold their previous value while a new operation is in flight.
   assign w_load_out = (w_state_nxt == DONE) && (r_state != DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_acc      <= 16'd0;
         r_rem      <= 4'd0;
         r_id       <= 1'b0;
         r_out_data <= 16'd0;
         r_out_id   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_rem   <= w_rem_nxt;
         r_id    <= w_id_nxt;
         if (w_load_out) begin
            r_out_data <= w_acc_nxt;
            r_out_id   <= w_id_nxt;
         end
      end
   end

   //------------------------------------------------------------------
   // Outputs
   //------------------------------------------------------------------
   assign bus.a_gnt     = w_a_gnt;
   assign bus.b_gnt     = w_b_gnt;
   assign bus.out_valid = (r_state == DONE);
   assign bus.out_data  = r_out_data;
   assign bus.out_id    = r_out_id;
   assign bus.busy      = (r_state != IDLE);

endmodule
